core_output_ctrl: RTL and testbench
===================================

Name: core_output_ctrl

Overview:
- Drain-side counterpart of the core input controller.
- Captures per-column results from the bottom edge of the N-column systolic array; columns emerge skewed by one cycle each.
- Buffers each column in its own FIFO and re-aligns (deskews) them into full rows.
- Presents each row through a registered valid/ready output stage to the downstream writeback logic.

Parameters:
- N, 8, number of array columns / FIFOs.
- OW, 24, result width per column in bits.
- DEPTH, 8, entries per column FIFO; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock; all state on posedge.
- rstn  in  1  asynchronous active-low reset.
- resport  in  N x OW  per-column result from array bottom row; index 0 = column 0.
- resvalid  in  N  per-column write strobe; bit j qualifies resport[j].
- fulls  out  N  per-column FIFO full flag.
- emptys  out  N  per-column FIFO empty flag.
- ovf  out  N  sticky per-column overflow (dropped write).
- row_data  out  N x OW  deskewed output row.
- row_valid  out  1  row_data is valid.
- row_ready  in  1  downstream accepts row when high with row_valid.
- row_cnt  out  16  rows accepted downstream; wraps 0xFFFF->0.

Behaviour:
- Reset (rstn low, asynchronous): all FIFO pointers 0; fulls=0, emptys=all 1, ovf=0, row_valid=0, row_data=0, row_cnt=0. FIFO storage is not reset.
- Mid-operation reset: all buffered data is discarded immediately; the first edge after release behaves as a fresh start.
- Per-column FIFO j:
  - Pointers carry an extra wrap bit. emptys[j] and fulls[j] are registered-state derived, not fall-through.
  - Push on posedge when resvalid[j] && (!fulls[j] || pop).
  - resvalid[j] while full with no pop that cycle: write dropped, ovf[j] set; it stays set until reset.
  - Push and pop in the same cycle are legal at any occupancy; occupancy is unchanged.
  - Pushed data is visible at the head on the cycle after the push edge.
- Pop (common to all columns): all_ne = &(~emptys); load = all_ne && (!row_valid || row_ready).
- On load:
  - every FIFO pops one entry;
  - row_data <= all N heads;
  - row_valid <= 1.
- Else if row_ready: row_valid <= 0.
- Else: row_valid and row_data hold.
- Output stability: row_data must not change while row_valid && !row_ready.
- Full throughput: with continuous data and row_ready=1, one row per cycle.
- Latency: if the last column's entry of a row is pushed at edge k, row_valid is high after edge k+1.
- row_cnt increments on each edge where row_valid && row_ready; wraps to 0.
- Columns may run arbitrarily far apart, up to DEPTH entries.

Test Plan:
- Reset: assert rstn=0 mid-run with data buffered -> immediately row_valid=0, emptys=8'hFF, ovf=0, row_cnt=0; the next row after release is the first row pushed post-reset.
- Skewed fill: column j pushes value 16*r+j for rows r=0..3, starting at cycle j; row_ready=1 -> four rows of {16r+0..16r+7}, in order. Row 0 valid after edge 8 (column-7 push at edge 7); row_cnt=4 at the end.
- Backpressure: hold row_ready=0 for 10 cycles with two rows buffered -> row_data frozen at row 0 and row_valid=1 throughout; on release, rows 0 then 1 appear on consecutive cycles.
- Full/overflow: row_ready=0, push 9 entries into column 3 only -> fulls[3]=1 after the 8th push, ovf[3]=1 after the 9th, all other ovf bits 0. Then fill the other columns and drain: rows 0..7 show column 3 data 0..7; the 9th value never appears.
- Simultaneous push/pop at full: all FIFOs full, row_ready=1, resvalid=all 1 for 5 cycles -> no ovf bits set, occupancy stays 8, row_cnt +5.
- Wrap: drain 0x10000 rows -> row_cnt reads 0; FIFO pointer wrap exercised over 3xDEPTH continuous rows with no data corruption.

Source files
------------

// File: rtl/core_output_ctrl_if.sv
// core_output_ctrl_if: row output bus from the output controller to writeback.
//   row_data  : N x OW deskewed row
//   row_valid : row_data holds a row
//   row_ready : downstream accepts the row this cycle
// master = output controller (drives data/valid), slave = writeback side.
interface core_output_ctrl_if #(
    parameter int N  = 8,
    parameter int OW = 24
);
    logic [N-1:0][OW-1:0] row_data;
    logic                 row_valid;
    logic                 row_ready;

    modport master (output row_data, output row_valid, input  row_ready);
    modport slave  (input  row_data, input  row_valid, output row_ready);
endinterface

// File: rtl/core_output_ctrl.sv
// core_output_ctrl: drain side of the systolic array. Each bottom-edge column
// result lands in its own FIFO. Columns emerge one cycle apart, and the FIFOs
// absorb that skew. A row is popped from all FIFOs at once only when every
// FIFO has data. That row is then held in a registered valid/ready stage.
//   clk, rstn  : clock, async active-low reset
//   resport    : per-column results (index 0 = column 0)
//   resvalid   : per-column write strobes
//   fulls      : per-column FIFO full flag
//   emptys     : per-column FIFO empty flag
//   ovf        : sticky per-column dropped-write flag
//   row_cnt    : rows accepted downstream (wraps)
//   row        : row output bus (master side)

// Per-column FIFO. Pointers carry an extra wrap bit so full and empty are
// distinguishable. Both flags come straight from registered pointers.
module core_output_ctrl_col #(
    parameter int OW    = 24,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          wr,
    input  logic [OW-1:0] wdata,
    input  logic          pop,
    output logic [OW-1:0] head,
    output logic          full,
    output logic          empty,
    output logic          ovf
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wptr, rptr;
    logic [OW-1:0] mem [DEPTH];
    logic          push;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    // A pop in the same cycle frees a slot, so a write at full is still taken.
    assign push  = wr && (!full || pop);
    assign head  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
            ovf  <= 1'b0;
        end else begin
            if (push)              wptr <= wptr + (AW+1)'(1);
            if (pop)               rptr <= rptr + (AW+1)'(1);
            if (wr && full && !pop) ovf <= 1'b1;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= wdata;
    end
endmodule

module core_output_ctrl #(
    parameter int N     = 8,
    parameter int OW    = 24,
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N-1:0][OW-1:0] resport,
    input  logic [N-1:0]         resvalid,
    output logic [N-1:0]         fulls,
    output logic [N-1:0]         emptys,
    output logic [N-1:0]         ovf,
    output logic [15:0]          row_cnt,
    core_output_ctrl_if.master   row
);
    logic [N-1:0][OW-1:0] heads;
    logic [N-1:0][OW-1:0] row_data_q;
    logic                 row_valid_q;
    logic                 all_ne;
    logic                 load;

    for (genvar j = 0; j < N; j++) begin : g_col
        core_output_ctrl_col #(.OW(OW), .DEPTH(DEPTH)) u_col (
            .clk   (clk),
            .rstn  (rstn),
            .wr    (resvalid[j]),
            .wdata (resport[j]),
            .pop   (load),
            .head  (heads[j]),
            .full  (fulls[j]),
            .empty (emptys[j]),
            .ovf   (ovf[j])
        );
    end

    // A row exists only once the slowest column has delivered. The output
    // register refills when it is empty or is being drained this cycle.
    assign all_ne = &(~emptys);
    assign load   = all_ne && (!row_valid_q || row.row_ready);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_valid_q <= 1'b0;
            row_data_q  <= '0;
            row_cnt     <= '0;
        end else begin
            if (load) begin
                row_valid_q <= 1'b1;
                row_data_q  <= heads;
            end else if (row.row_ready) begin
                row_valid_q <= 1'b0;
            end
            if (row_valid_q && row.row_ready) row_cnt <= row_cnt + 16'd1;
        end
    end

    assign row.row_valid = row_valid_q;
    assign row.row_data  = row_data_q;
endmodule

// File: tb/tb_core_output_ctrl.sv
module tb_core_output_ctrl;
    localparam int N = 8, OW = 24, DEPTH = 8;
    typedef logic [N-1:0][OW-1:0] row_t;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    row_t         resport = '0;
    logic [N-1:0] resvalid = '0;
    logic [N-1:0] fulls, emptys, ovf;
    logic [15:0]  row_cnt;

    core_output_ctrl_if #(.N(N), .OW(OW)) rif ();

    core_output_ctrl #(.N(N), .OW(OW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .resport  (resport),
        .resvalid (resvalid),
        .fulls    (fulls),
        .emptys   (emptys),
        .ovf      (ovf),
        .row_cnt  (row_cnt),
        .row      (rif.master)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    row_t sb[$];

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", nm, got, exp);
        else n_pass++;
    endtask

    // Monitor: every accepted row is compared with the oldest expected row.
    always @(negedge clk) begin
        if (rstn && rif.row_valid && rif.row_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL row_unexpected: got %h expected none", rif.row_data);
            end else begin
                chk("row_data", rif.row_data, sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_row(input row_t d, input logic [N-1:0] v);
        resport  = d;
        resvalid = v;
        step();
        resvalid = '0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rstn = 1'b0;
        sb.delete();
        step();
        rstn = 1'b1;
    endtask

    task automatic drain(input string nm, input int max_cyc);
        int t = 0;
        while (sb.size() != 0 && t < max_cyc) begin
            step();
            t++;
        end
        step();
        chk(nm, sb.size(), 0);
    endtask

    initial begin
        row_t d;
        rif.row_ready = 1'b0;

        // Initial reset state.
        #1;
        chk("rst_valid", rif.row_valid, 0);
        chk("rst_emptys", emptys, 8'hFF);
        chk("rst_fulls", fulls, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_cnt", row_cnt, 0);
        chk("rst_data", rif.row_data, 0);
        step();
        rstn = 1'b1;

        // Skewed fill: column j pushes 16r+j starting at edge j.
        rif.row_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < N; j++) d[j] = 24'(16 * r + j);
            sb.push_back(d);
        end
        for (int c = 0; c < 11; c++) begin
            for (int j = 0; j < N; j++) begin
                if (c - j >= 0 && c - j < 4) begin
                    resvalid[j] = 1'b1;
                    resport[j]  = 24'(16 * (c - j) + j);
                end else begin
                    resvalid[j] = 1'b0;
                end
            end
            step();
            if (c == 7) chk("lat_before", rif.row_valid, 0);
            if (c == 8) chk("lat_after", rif.row_valid, 1);
        end
        resvalid = '0;
        repeat (4) step();
        chk("skew_cnt", row_cnt, 4);
        chk("skew_sb", sb.size(), 0);

        // Backpressure: two rows buffered, ready low for 10 cycles.
        rif.row_ready = 1'b0;
        do_reset();
        for (int r = 1; r <= 2; r++) begin
            for (int j = 0; j < N; j++) d[j] = 24'(256 * r + j);
            sb.push_back(d);
            push_row(d, '1);
        end
        step();
        for (int j = 0; j < N; j++) d[j] = 24'(256 + j);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_valid", rif.row_valid, 1);
            chk("bp_data", rif.row_data, d);
        end
        rif.row_ready = 1'b1;
        step();
        step();
        chk("bp_cnt", row_cnt, 2);
        chk("bp_done", rif.row_valid, 0);

        // Full/overflow on column 3 alone.
        rif.row_ready = 1'b0;
        do_reset();
        d = '0;
        for (int i = 0; i < 9; i++) begin
            d[3] = 24'(i);
            push_row(d, 8'h08);
            if (i == 7) begin
                chk("ovf_full", fulls, 8'h08);
                chk("ovf_none", ovf, 0);
            end
            if (i == 8) chk("ovf_set", ovf, 8'h08);
        end
        for (int r = 0; r < 8; r++) begin
            for (int j = 0; j < N; j++) d[j] = (j == 3) ? 24'(r) : 24'(32'h1000 + 16 * r + j);
            sb.push_back(d);
            push_row(d, 8'hF7);
        end
        rif.row_ready = 1'b1;
        drain("ovf_drain", 30);
        chk("ovf_sticky", ovf, 8'h08);
        chk("ovf_cnt", row_cnt, 8);

        // Mid-run reset with data buffered and ovf set.
        rif.row_ready = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < N; j++) d[j] = 24'(32'h500 + 16 * r + j);
            push_row(d, '1);
        end
        step();
        rstn = 1'b0;
        sb.delete();
        #1;
        chk("mrst_valid", rif.row_valid, 0);
        chk("mrst_emptys", emptys, 8'hFF);
        chk("mrst_fulls", fulls, 0);
        chk("mrst_ovf", ovf, 0);
        chk("mrst_cnt", row_cnt, 0);
        chk("mrst_data", rif.row_data, 0);
        #2 rstn = 1'b1;
        rif.row_ready = 1'b1;
        for (int j = 0; j < N; j++) d[j] = 24'(32'h3000 + j);
        sb.push_back(d);
        step();
        push_row(d, '1);
        drain("mrst_drain", 10);
        chk("mrst_cnt1", row_cnt, 1);

        // Simultaneous push/pop at full.
        rif.row_ready = 1'b0;
        do_reset();
        for (int r = 0; r < 9; r++) begin
            for (int j = 0; j < N; j++) d[j] = 24'(32'h2000 + 16 * r + j);
            sb.push_back(d);
            push_row(d, '1);
        end
        step();
        chk("sim_full", fulls, 8'hFF);
        chk("sim_valid", rif.row_valid, 1);
        rif.row_ready = 1'b1;
        for (int r = 9; r < 14; r++) begin
            for (int j = 0; j < N; j++) d[j] = 24'(32'h2000 + 16 * r + j);
            sb.push_back(d);
            push_row(d, '1);
        end
        chk("sim_ovf", ovf, 0);
        chk("sim_still_full", fulls, 8'hFF);
        chk("sim_cnt5", row_cnt, 5);
        drain("sim_drain", 30);
        chk("sim_cnt14", row_cnt, 14);

        // Counter wrap: 0x10000 rows at full throughput.
        do_reset();
        rif.row_ready = 1'b1;
        for (int r = 0; r < 65536; r++) begin
            for (int j = 0; j < N; j++) d[j] = 24'(16 * r + j);
            sb.push_back(d);
            push_row(d, '1);
        end
        drain("wrap_drain", 20);
        chk("wrap_cnt", row_cnt, 0);
        chk("wrap_ovf", ovf, 0);
        chk("wrap_empty", emptys, 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
